// File: rtl/uart_tx_fsm.sv
// uart_tx_fsm: UART transmit frame sequencer.
// Serialises a parallel word LSB-first and steers the TX output mux through
// the start, data, optional parity and stop legs. CLK is the baud clock, so
// each CLK cycle is one bit period.
// Optional feature macro: UART_TX_TWO_STOP_EN adds a second stop bit (STOP2).
module uart_tx_fsm #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  data_valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [1:0]            mux_sel,
    output logic                  ser_data,
    output logic                  par_bit,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
`ifdef UART_TX_TWO_STOP_EN
    localparam logic [2:0] STOP2  = 3'd5;
    // A new word may only be taken in the last stop bit.
    localparam logic [2:0] FINAL_STATE = STOP2;
`else
    localparam logic [2:0] FINAL_STATE = STOP;
`endif

    logic [2:0]            state;
    logic [2:0]            state_next;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  par_en_lat;
    logic                  accept;

    assign accept   = data_valid && ((state == IDLE) || (state == FINAL_STATE));
    assign ser_data = shift_reg[0];

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; frame configuration comes only from latched values.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = START;
                end
            end
            START: begin
                state_next = DATA;
            end
            DATA: begin
                if (bit_cnt == LAST_BIT) begin
                    state_next = par_en_lat ? PARITY : STOP;
                end
            end
            PARITY: begin
                state_next = STOP;
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP: begin
                state_next = STOP2;
            end
            STOP2: begin
                state_next = accept ? START : IDLE;
            end
`else
            STOP: begin
                state_next = accept ? START : IDLE;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch word/config and parity on accept, shift during DATA.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            par_en_lat <= 1'b0;
            par_bit    <= 1'b0;
        end else if (accept) begin
            shift_reg  <= P_DATA;
            bit_cnt    <= '0;
            par_en_lat <= PAR_EN;
            par_bit    <= PAR_TYP ? ~^P_DATA : ^P_DATA;
        end else if (state == DATA) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
        end
    end

    // Output decode from the state register only.
    always_comb begin
        mux_sel = 2'b11;
        busy    = 1'b0;
        case (state)
            START: begin
                mux_sel = 2'b00;
                busy    = 1'b1;
            end
            DATA: begin
                mux_sel = 2'b01;
                busy    = 1'b1;
            end
            PARITY: begin
                mux_sel = 2'b10;
                busy    = 1'b1;
            end
            STOP: begin
                mux_sel = 2'b11;
                busy    = 1'b1;
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP2: begin
                mux_sel = 2'b11;
                busy    = 1'b1;
            end
`endif
            default: begin
                mux_sel = 2'b11;
                busy    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// tb_uart_tx_fsm: self-checking bench for uart_tx_fsm.
// The reference model tracks a frame as a position counter into the
// symbol sequence start, data[0..DW-1], [parity], stop(s).
module tb_uart_tx_fsm;

    localparam int unsigned DW = 8;
`ifdef UART_TX_TWO_STOP_EN
    localparam int unsigned NSTOP = 2;
`else
    localparam int unsigned NSTOP = 1;
`endif

    logic          CLK;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [1:0]    mux_sel;
    logic          ser_data;
    logic          par_bit;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    bit            m_busy = 1'b0;
    int            m_pos  = 0;
    int            m_len  = 0;
    logic [DW-1:0] m_word = '0;
    bit            m_pen  = 1'b0;
    bit            m_ptyp = 1'b0;

    uart_tx_fsm #(.DATA_WIDTH(DW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .mux_sel    (mux_sel),
        .ser_data   (ser_data),
        .par_bit    (par_bit),
        .busy       (busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        assert (act === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, act, exp);
    endtask

    // Advance the model by one clock edge with the inputs the DUT sampled.
    task automatic model_edge(input bit dv, input logic [DW-1:0] d, input bit pen, input bit ptyp);
        if (dv && (!m_busy || m_pos == m_len - 1)) begin
            m_busy = 1'b1;
            m_pos  = 0;
            m_word = d;
            m_pen  = pen;
            m_ptyp = ptyp;
            m_len  = 1 + int'(DW) + int'(pen) + int'(NSTOP);
        end else if (m_busy) begin
            m_pos++;
            if (m_pos == m_len) m_busy = 1'b0;
        end
    endtask

    task automatic compare_all();
        logic [1:0] exp_mux;
        if (!m_busy)                              exp_mux = 2'b11;
        else if (m_pos == 0)                      exp_mux = 2'b00;
        else if (m_pos <= int'(DW))               exp_mux = 2'b01;
        else if (m_pen && m_pos == int'(DW) + 1)  exp_mux = 2'b10;
        else                                      exp_mux = 2'b11;
        check("mux_sel", {14'd0, mux_sel}, {14'd0, exp_mux});
        check("busy", {15'd0, busy}, {15'd0, m_busy});
        if (m_busy && m_pos >= 1 && m_pos <= int'(DW))
            check("ser_data", {15'd0, ser_data}, {15'd0, m_word[m_pos-1]});
        if (m_busy)
            check("par_bit", {15'd0, par_bit},
                  16'(($countones(m_word) % 2) ^ int'(m_ptyp)));
    endtask

    task automatic step(input bit dv, input logic [DW-1:0] d, input bit pen, input bit ptyp);
        @(negedge CLK);
        data_valid = dv;
        P_DATA     = d;
        PAR_EN     = pen;
        PAR_TYP    = ptyp;
        @(posedge CLK);
        model_edge(dv, d, pen, ptyp);
        #1;
        compare_all();
    endtask

    initial begin
        int cnt;
        RST        = 1'b1;
        P_DATA     = '0;
        data_valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        #3;
        check("rst_mux_sel", {14'd0, mux_sel}, 16'h3);
        check("rst_busy", {15'd0, busy}, 16'h0);
        check("rst_ser_data", {15'd0, ser_data}, 16'h0);
        check("rst_par_bit", {15'd0, par_bit}, 16'h0);
        @(negedge CLK);
        RST = 1'b0;

        // Even parity, 8'hA5.
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        repeat (DW + 4) step(1'b0, 8'h00, 1'b0, 1'b0);

        // Odd parity on 8'h01, then the same word without parity.
        step(1'b1, 8'h01, 1'b1, 1'b1);
        repeat (DW + 4) step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h01, 1'b0, 1'b1);
        cnt = busy ? 1 : 0;
        repeat (DW + 5) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            if (busy) cnt++;
        end
        check("frame_len_nopar", 16'(cnt), 16'(1 + DW + NSTOP));

        // Back-to-back: valid held high, second word presented from the start.
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        repeat (DW + 3 + NSTOP) step(1'b1, 8'hC3, 1'b1, 1'b1);
        repeat (DW + 4) step(1'b0, 8'h00, 1'b0, 1'b0);

        // Ignored request and config changes mid-frame.
        step(1'b1, 8'h5A, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        repeat (DW + 4) step(1'b0, 8'h00, 1'b0, 1'b0);

        // Two-stop build: 8'h55 without parity.
        step(1'b1, 8'h55, 1'b0, 1'b0);
        repeat (DW + 4) step(1'b0, 8'h00, 1'b0, 1'b0);

        // Asynchronous reset in the middle of DATA.
        step(1'b1, 8'hA5, 1'b1, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);
        #1 RST = 1'b1;
        #1;
        m_busy = 1'b0;
        check("midrst_mux_sel", {14'd0, mux_sel}, 16'h3);
        check("midrst_busy", {15'd0, busy}, 16'h0);
        check("midrst_ser_data", {15'd0, ser_data}, 16'h0);
        @(negedge CLK);
        RST        = 1'b0;
        data_valid = 1'b0;
        repeat (DW + 4) step(1'b0, 8'h00, 1'b0, 1'b0);

        // Random traffic with random mid-frame input changes.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) == 0), DW'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end
        repeat (DW + 5) step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
